ex_muldiv: RTL and testbench

- Execute-stage iterative multiply/divide unit that consumes operand_1/operand_2 produced by the ID-stage operand generator for SPECIAL MULT/MULTU/DIV/DIVU.
- Writes a 64-bit result into HI/LO.
- Raises busy while iterating so the pipeline controller can stall issue of dependent MFHI/MFLO.
- Sits beside the ALU in EX; its outputs feed the HI/LO register file.

---
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for SPECIAL MULT/MULTU/DIV/DIVU, writing HI/LO.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single combinational cycle.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] counter;
    logic [2*W-1:0]   acc;        // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [W-1:0]     opb;        // multiplicand or divisor magnitude
    logic [W-1:0]     op1_raw;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    // Request decode: funct 0x18..0x1B, bit1 selects divide, bit0 selects unsigned.
    logic         legal, req_div, req_signed, op1_neg, op2_neg, accept, fast_mul;
    logic [W-1:0] abs1, abs2;

    assign legal      = (funct[5:2] == 4'b0110);
    assign req_div    = funct[1];
    assign req_signed = ~funct[0];
    assign op1_neg    = req_signed & operand_1[W-1];
    assign op2_neg    = req_signed & operand_2[W-1];
    assign abs1       = op1_neg ? -operand_1 : operand_1;
    assign abs2       = op2_neg ? -operand_2 : operand_2;
    assign accept     = start & legal & ~flush & ((state == S_IDLE) || (state == S_DONE));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_mag, fast_res;
    assign fast_mul = accept & ~req_div;
    assign fast_mag = {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2};
    assign fast_res = (op1_neg ^ op2_neg) ? -fast_mag : fast_mag;
`else
    assign fast_mul = 1'b0;
`endif

    // One radix-2 step of either algorithm, computed from the current working registers.
    logic [W:0]     mul_sum, rem_sh, rem_new;
    logic           rem_ge;
    logic [2*W-1:0] acc_next, mul_prod;
    logic [W-1:0]   quot, rem, res_hi, res_lo;
    logic           last_step;

    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    assign rem_sh   = acc[2*W-1:W-1];
    assign rem_ge   = (rem_sh >= {1'b0, opb});
    assign rem_new  = rem_ge ? (rem_sh - {1'b0, opb}) : rem_sh;
    assign acc_next = is_div ? {rem_new[W-1:0], acc[W-2:0], rem_ge}
                             : {mul_sum, acc[W-1:1]};

    // Sign correction of the final step, registered into hi/lo on entry to DONE.
    assign mul_prod = neg_q ? -acc_next : acc_next;
    assign quot     = acc_next[W-1:0];
    assign rem      = acc_next[2*W-1:W];

    always_comb begin
        res_hi = mul_prod[2*W-1:W];
        res_lo = mul_prod[W-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = op1_raw;
                res_lo = {W{1'b1}};
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -quot : quot;
            end
        end
    end

    assign last_step = (state == S_CALC) && (counter == LAST_STEP) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_next = fast_mul ? S_DONE : S_CALC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (counter == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            acc      <= '0;
            opb      <= '0;
            op1_raw  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            counter  <= '0;
            acc      <= {{W{1'b0}}, (req_div ? abs1 : abs2)};
            opb      <= req_div ? abs2 : abs1;
            op1_raw  <= operand_1;
            is_div   <= req_div;
            neg_q    <= op1_neg ^ op2_neg;
            neg_r    <= op1_neg;
            div_zero <= (operand_2 == '0);
        end else if (state == S_CALC) begin
            counter <= counter + 1'b1;
            acc     <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (fast_mul) begin
            hi <= fast_res[2*W-1:W];
            lo <= fast_res[W-1:0];
        end
`endif
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, multi-cycle corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_ex_muldiv;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    ex_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sp;
        int     sa, sb;
        logic [63:0] r;
        r = '0;
        case (f)
            F_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = sp;
            end
            F_MULTU: r = {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sa = a;
                    sb = b;
                    r  = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [5:0] f);
        return (FAST && !f[1]) ? 1 : 33;
    endfunction

    // Drives a request and returns just after the accepting edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        operand_1 = a;
        operand_2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges (the accepting one included) until done, bounded.
    task automatic wait_done(output int cycles, output int busy_cyc);
        cycles = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic run_check(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
        int cyc, bcyc;
        issue(f, a, b);
        wait_done(cyc, bcyc);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " result"}, {hi, lo}, exp);
        check({name, " latency"}, 64'(cyc), 64'(exp_latency(f)));
        check({name, " busy cycles"}, 64'(bcyc), 64'(exp_latency(f) - 1));
        @(posedge clk);
        #1;
        check({name, " done pulse"}, 64'(done), 64'd0);
    endtask

    vec_t table_v[12];

    initial begin
        int cyc, bcyc;

        table_v[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        table_v[1]  = '{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        table_v[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        table_v[3]  = '{F_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        table_v[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        table_v[5]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        table_v[6]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        table_v[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        table_v[8]  = '{F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        table_v[9]  = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        table_v[10] = '{F_MULTU, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        table_v[11] = '{F_DIVU,  32'h0000_0023, 32'h0000_0006, 32'h0000_0005, 32'h0000_0005};

        // Reset state
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("vec%0d", i), table_v[i].f, table_v[i].a, table_v[i].b,
                      {table_v[i].exp_hi, table_v[i].exp_lo});
        end

        // Illegal funct is ignored.
        issue(6'h20, 32'd3, 32'd4);
        check("illegal busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal done", 64'(done), 64'd0);
        check("illegal hilo", {hi, lo}, 64'h0000_0005_0000_0005);

        // Flush ten cycles into DIVU 100/7 with hi=lo=5 from the last table entry.
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hilo", {hi, lo}, 64'h0000_0005_0000_0005);
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) cyc++;
        end
        check("flush quiet", 64'(cyc), 64'd0);
        run_check("restart", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

        // Flush outranks a simultaneous start.
        start = 1'b1;
        funct = F_DIVU;
        operand_1 = 32'd50;
        operand_2 = 32'd5;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush vs start", 64'({busy, done}), 64'd0);

        // Back-to-back: restart in the DONE cycle, then ignore starts during CALC.
        issue(F_MULTU, 32'd3, 32'd5);
        wait_done(cyc, bcyc);
        check("b2b first latency", 64'(cyc), 64'(exp_latency(F_MULTU)));
        check("b2b first result", {hi, lo}, {32'd0, 32'd15});
        issue(F_DIVU, 32'd9, 32'd4);
        check("b2b accepted", 64'(busy), 64'd1);
        start = 1'b1;
        funct = F_DIVU;
        operand_1 = 32'd100;
        operand_2 = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("b2b second latency", 64'(cyc + 3), 64'd33);
        check("b2b second result", {hi, lo}, {32'd1, 32'd2});

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_check($sformatf("rand%0d f=%0h a=%0h b=%0h", i, f, a, b), f, a, b, model(f, a, b));
        end

        // Asynchronous reset mid-operation aborts without a done pulse.
        issue(F_MULTU, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset hilo", {hi, lo}, 64'd0);
        #3 rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) cyc++;
        end
        check("post reset no done", 64'(cyc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
